vector_sweep_ctrl: RTL and testbench

// Sequencer for a 6-input combinational logic unit (ports a..f -> y). On start it

---
 rtl/vector_sweep_ctrl_if.sv | 42 ++++
 rtl/vector_sweep_ctrl.sv | 100 ++++++++++
 tb/tb_vector_sweep_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vector_sweep_ctrl_if.sv
// Bundle between the sweep sequencer, its config master and the swept unit.
// The master side also supplies y_in from the combinational unit.
interface vector_sweep_ctrl_if #(
   parameter int N_IN = 6
);
   logic                   start;
   logic                   abort;
   logic                   y_in;
   logic [N_IN-1:0]        vec_out;
   logic                   busy;
   logic                   done;
   logic [(1<<N_IN)-1:0]   truth;
   logic [N_IN:0]          ones_cnt;
   logic                   found;
   logic [N_IN-1:0]        first_one;

   modport master (
      output start,
      output abort,
      output y_in,
      input  vec_out,
      input  busy,
      input  done,
      input  truth,
      input  ones_cnt,
      input  found,
      input  first_one
   );

   modport slave (
      input  start,
      input  abort,
      input  y_in,
      output vec_out,
      output busy,
      output done,
      output truth,
      output ones_cnt,
      output found,
      output first_one
   );
endinterface

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input sweep of a combinational unit, collecting its
// truth table, ones count and lowest vector that drives y high.
module vector_sweep_ctrl #(
   parameter int N_IN   = 6,
   parameter int SETTLE = 2
) (
   input logic                clk,
   input logic                rst,
   vector_sweep_ctrl_if.slave bus
);
   localparam int NV = 1 << N_IN;
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [N_IN-1:0] LAST = N_IN'(NV - 1);
   localparam logic [CW-1:0]   RELOAD = CW'(SETTLE);

   typedef enum logic [1:0] {
      IDLE,
      SETL,
      SMPL
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [N_IN-1:0] idx;
   logic            busy_r;
   logic            done_r;
   logic [NV-1:0]   truth_r;
   logic [N_IN:0]   ones_r;
   logic            found_r;
   logic [N_IN-1:0] first_r;

   assign bus.vec_out   = idx;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.truth     = truth_r;
   assign bus.ones_cnt  = ones_r;
   assign bus.found     = found_r;
   assign bus.first_one = first_r;

   // idx doubles as vec_out, so it returns to 0 whenever the sweep ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         truth_r <= '0;
         ones_r  <= '0;
         found_r <= 1'b0;
         first_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (bus.abort) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            idx    <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (bus.start) begin
                     truth_r <= '0;
                     ones_r  <= '0;
                     found_r <= 1'b0;
                     first_r <= '0;
                     idx     <= '0;
                     cnt     <= RELOAD;
                     busy_r  <= 1'b1;
                     state   <= SETL;
                  end
               end
               SETL: begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1))
                     state <= SMPL;
               end
               SMPL: begin
                  truth_r[idx] <= bus.y_in;
                  ones_r <= ones_r + {{N_IN{1'b0}}, bus.y_in};
                  if (bus.y_in && !found_r) begin
                     found_r <= 1'b1;
                     first_r <= idx;
                  end
                  if (idx == LAST) begin
                     busy_r <= 1'b0;
                     done_r <= 1'b1;
                     idx    <= '0;
                     state  <= IDLE;
                  end else begin
                     idx   <= idx + 1'b1;
                     cnt   <= RELOAD;
                     state <= SETL;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Bench for vector_sweep_ctrl: table of unit functions with expected
// sweep results, plus restart, abort and mid-sweep reset sequences.
module tb_vector_sweep_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int          mode;
      logic [63:0] truth;
      logic [6:0]  ones;
      logic        found;
      logic [5:0]  first;
   } vec_t;

   vec_t tbl[5];
   vec_t sb[$];

   vector_sweep_ctrl_if #(.N_IN(6)) bus();

   vector_sweep_ctrl #(.N_IN(6), .SETTLE(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic ymodel(input int m, input logic [5:0] v);
      case (m)
         0: return v == 6'd37;
         1: return 1'b1;
         2: return 1'b0;
         3: return v >= 6'd60;
         default: return v[0];
      endcase
   endfunction

   assign bus.y_in = ymodel(mode, bus.vec_out);

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string nm, input vec_t e);
      chk({nm, "_truth"}, bus.truth, e.truth);
      chk({nm, "_ones"}, 64'(bus.ones_cnt), 64'(e.ones));
      chk({nm, "_found"}, 64'(bus.found), 64'(e.found));
      chk({nm, "_first"}, 64'(bus.first_one), 64'(e.first));
   endtask

   task automatic sweep(input int ti, input bit restart);
      vec_t e;
      int dk;
      int verr;
      mode = tbl[ti].mode;
      sb.push_back(tbl[ti]);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      dk = -1;
      verr = 0;
      for (int k = 0; k < 400 && dk < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (restart && k == 10) bus.start = 1'b1;
         if (restart && k == 11) bus.start = 1'b0;
         if (bus.done) dk = k;
         else if (k < 192 && (bus.vec_out !== 6'(k / 3) || !bus.busy))
            verr++;
      end
      chk("done_lat", 64'(dk), 64'd192);
      chk("vec_seq", 64'(verr), 64'd0);
      chk("end_busy", 64'(bus.busy), 64'd0);
      chk("end_vec", 64'(bus.vec_out), 64'd0);
      @(negedge clk);
      chk("done_pulse", 64'(bus.done), 64'd0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk_res("res", e);
      end else begin
         chk("sb_empty", 64'd1, 64'd0);
      end
   endtask

   initial begin
      vec_t ab;
      int dcnt;
      tbl[0] = '{0, 64'h1 << 37, 7'd1, 1'b1, 6'd37};
      tbl[1] = '{1, {64{1'b1}}, 7'd64, 1'b1, 6'd0};
      tbl[2] = '{2, 64'h0, 7'd0, 1'b0, 6'd0};
      tbl[3] = '{3, 64'hF000_0000_0000_0000, 7'd4, 1'b1, 6'd60};
      tbl[4] = '{4, 64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 1'b1, 6'd1};
      bus.start = 1'b0;
      bus.abort = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_vec", 64'(bus.vec_out), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk_res("rst", tbl[2]);
      rst = 1'b0;

      for (int i = 0; i < 5; i++)
         sweep(i, i == 0);

      // results hold, and abort beats start in IDLE
      repeat (5) @(negedge clk);
      chk_res("hold", tbl[4]);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("sa_busy", 64'(bus.busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("sa_busy2", 64'(bus.busy), 64'd0);
      chk_res("sa", tbl[4]);

      // restart ignored mid-sweep
      sweep(3, 1'b1);

      // abort at cycle 50
      mode = 1;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (50) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk) bus.abort = 1'b0;
      chk("ab_busy", 64'(bus.busy), 64'd0);
      chk("ab_vec", 64'(bus.vec_out), 64'd0);
      dcnt = 0;
      for (int k = 0; k < 250; k++) begin
         if (bus.done) dcnt++;
         @(negedge clk);
      end
      chk("ab_nodone", 64'(dcnt), 64'd0);
      ab = '{1, 64'hFFFF, 7'd16, 1'b1, 6'd0};
      chk_res("ab", ab);

      // reset at cycle 100 of a sweep
      mode = 0;
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mr_busy", 64'(bus.busy), 64'd0);
      chk("mr_vec", 64'(bus.vec_out), 64'd0);
      chk("mr_done", 64'(bus.done), 64'd0);
      chk_res("mr", tbl[2]);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sweep(0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
